// File: rtl/mac_seq_pkg.sv
// Shared types and configuration helpers for the neuron MAC frame sequencer.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  localparam int DEF_N_TAPS      = 28;
  localparam int DEF_N_LANES     = 28;
  localparam int DEF_SHIFT_START = 24;
  localparam int DEF_FRAME_LEN   = 66;

  // Frame must fit the whole tap phase plus enx/out_valid,
  // and the full lane walk plus its final hold cycle.
  function automatic bit frame_len_ok(input int n_taps, input int n_lanes,
                                      input int shift_start, input int frame_len);
    return (frame_len >= n_taps + 2) && (frame_len >= shift_start + n_lanes + 1);
  endfunction

endpackage

// File: rtl/onehot_shifter.sv
// One-hot walking enable: load sets bit 0, shift moves it left, clear zeroes it.
module onehot_shifter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (clear)  q <= '0;
    else if (load)   q <= W'(1);
    else if (shift)  q <= q << 1;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Frame sequencer for the neuron MAC array: tap stepping, lane walk, enx strobe
// and a valid/ready result hold with back-to-back frame support.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int N_TAPS      = DEF_N_TAPS,
  parameter int N_LANES     = DEF_N_LANES,
  parameter int SHIFT_START = DEF_SHIFT_START,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int SEL_W       = $clog2(N_TAPS),
  parameter int CNT_W       = $clog2(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               GlobalReset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   tap_sel,
  output logic               acc_en,
  output logic [N_LANES-1:0] lane_en,
  output logic               enx,
  output logic               out_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  if (!frame_len_ok(N_TAPS, N_LANES, SHIFT_START, FRAME_LEN)) begin : g_bad_cfg
    $error("mac_seq_ctrl: FRAME_LEN too short for N_TAPS/N_LANES/SHIFT_START");
  end

  localparam logic [CNT_W-1:0] LAST_FC  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ENX_FC   = CNT_W'(FRAME_LEN - 2);
  localparam logic [CNT_W-1:0] TAP_END  = CNT_W'(N_TAPS);
  localparam logic [CNT_W-1:0] SH_FIRST = CNT_W'(SHIFT_START);
  localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SHIFT_START + N_LANES - 2);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_TAPS - 1);

  seq_state_e       state, state_n;
  logic [CNT_W-1:0] fc, fc_n;
  logic             lane_ld, lane_sh, lane_clr;

  assign frame_cnt = fc;

  always_comb begin
    state_n  = state;
    fc_n     = fc;
    lane_ld  = 1'b0;
    lane_sh  = 1'b0;
    lane_clr = 1'b0;
    if (abort) begin
      state_n  = IDLE;
      fc_n     = '0;
      lane_clr = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = RUN;
          fc_n    = '0;
          lane_ld = 1'b1;
        end
        RUN: if (fc == ENX_FC) begin
          state_n  = HOLD;
          fc_n     = LAST_FC;
          lane_clr = 1'b1;
        end else begin
          fc_n    = fc + 1'b1;
          lane_sh = (fc >= SH_FIRST) && (fc <= SH_LAST);
        end
        // start is only honoured here alongside a completed transfer
        HOLD: if (out_ready) begin
          fc_n = '0;
          if (start) begin
            state_n = RUN;
            lane_ld = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n  = IDLE;
          fc_n     = '0;
          lane_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state/count so they line up with fc.
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state     <= IDLE;
      fc        <= '0;
      tap_sel   <= '0;
      acc_en    <= 1'b0;
      enx       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      fc        <= fc_n;
      tap_sel   <= (state_n == IDLE) ? '0 :
                   (fc_n < TAP_END)  ? SEL_W'(fc_n) : SEL_MAX;
      acc_en    <= (state_n == RUN) && (fc_n < TAP_END);
      enx       <= (state_n == RUN) && (fc_n == ENX_FC);
      out_valid <= (state_n == HOLD);
      busy      <= (state_n != IDLE);
    end
  end

  onehot_shifter #(.W(N_LANES)) u_lane (
    .clk   (clk),
    .rst_n (GlobalReset_n),
    .load  (lane_ld),
    .shift (lane_sh),
    .clear (lane_clr),
    .q     (lane_en)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: default 28/28/24/66 instance plus a 9/4/3/12 instance.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, out_ready;
  logic [4:0]  tap_sel;
  logic        acc_en, enx, out_valid, busy;
  logic [27:0] lane_en;
  logic [6:0]  frame_cnt;

  logic s_start, s_abort, s_ready;
  logic [3:0] s_tap;
  logic       s_acc, s_enx, s_ov, s_busy;
  logic [3:0] s_lane;
  logic [3:0] s_fc;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk(clk), .GlobalReset_n(rst_n), .start(start), .abort(abort),
    .out_ready(out_ready), .tap_sel(tap_sel), .acc_en(acc_en), .lane_en(lane_en),
    .enx(enx), .out_valid(out_valid), .busy(busy), .frame_cnt(frame_cnt)
  );

  mac_seq_ctrl #(.N_TAPS(9), .N_LANES(4), .SHIFT_START(3), .FRAME_LEN(12)) dut_s (
    .clk(clk), .GlobalReset_n(rst_n), .start(s_start), .abort(s_abort),
    .out_ready(s_ready), .tap_sel(s_tap), .acc_en(s_acc), .lane_en(s_lane),
    .enx(s_enx), .out_valid(s_ov), .busy(s_busy), .frame_cnt(s_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " lane"}, 32'(lane_en), 0);
    chk({tag, " acc"}, 32'(acc_en), 0);
    chk({tag, " enx"}, 32'(enx), 0);
    chk({tag, " ov"}, 32'(out_valid), 0);
    chk({tag, " tap"}, 32'(tap_sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_enx, n_ov, n_bsy;
    logic [31:0] e_lane, e_tap;
    rst_n = 1'b0; start = 0; abort = 0; out_ready = 1;
    s_start = 0; s_abort = 0; s_ready = 1;
    step(); step();
    chk_idle("reset");
    chk("reset fc", 32'(frame_cnt), 0);
    chk("reset s_busy", 32'(s_busy), 0);
    rst_n = 1'b1;
    step();
    chk_idle("post-reset");

    // Full frame with out_ready tied high
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 66; i++) begin
      e_tap  = (i < 28) ? i : 27;
      e_lane = (i == 65) ? 0 : (i <= 24) ? 1 : (i >= 51) ? (32'd1 << 27) : (32'd1 << (i - 24));
      chk($sformatf("fc@%0d", i), 32'(frame_cnt), i);
      chk($sformatf("acc@%0d", i), 32'(acc_en), (i < 28) ? 1 : 0);
      chk($sformatf("tap@%0d", i), 32'(tap_sel), e_tap);
      chk($sformatf("lane@%0d", i), 32'(lane_en), e_lane);
      chk($sformatf("enx@%0d", i), 32'(enx), (i == 64) ? 1 : 0);
      chk($sformatf("ov@%0d", i), 32'(out_valid), (i == 65) ? 1 : 0);
      chk($sformatf("busy@%0d", i), 32'(busy), 1);
      step();
    end
    chk_idle("after frame");

    // Stalled HOLD, then back-to-back frame
    out_ready = 0; start = 1;
    step();
    start = 0;
    repeat (65) step();
    chk("hold entry ov", 32'(out_valid), 1);
    chk("hold entry fc", 32'(frame_cnt), 65);
    start = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("stall ov@%0d", i), 32'(out_valid), 1);
      chk($sformatf("stall fc@%0d", i), 32'(frame_cnt), 65);
      chk($sformatf("stall busy@%0d", i), 32'(busy), 1);
    end
    out_ready = 1;
    step();
    start = 0;
    chk("b2b fc", 32'(frame_cnt), 0);
    chk("b2b acc", 32'(acc_en), 1);
    chk("b2b busy", 32'(busy), 1);
    chk("b2b ov", 32'(out_valid), 0);
    chk("b2b lane", 32'(lane_en), 1);

    // Abort at fc=30
    repeat (30) step();
    chk("pre-abort fc", 32'(frame_cnt), 30);
    abort = 1;
    step();
    abort = 0;
    chk_idle("abort");
    chk("abort fc", 32'(frame_cnt), 0);
    n_enx = 0; n_ov = 0;
    repeat (70) begin
      step();
      n_enx += int'(enx); n_ov += int'(out_valid);
    end
    chk("abort no enx", n_enx, 0);
    chk("abort no ov", n_ov, 0);
    start = 1;
    step();
    start = 0;
    chk("restart fc", 32'(frame_cnt), 0);
    chk("restart acc", 32'(acc_en), 1);
    chk("restart lane", 32'(lane_en), 1);
    chk("restart tap", 32'(tap_sel), 0);

    // Async reset between edges at fc=40
    repeat (40) step();
    chk("pre-rst fc", 32'(frame_cnt), 40);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async rst");
    chk("async rst fc", 32'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_bsy = 0;
    repeat (20) begin
      step();
      n_bsy += int'(busy) + int'(acc_en) + int'(enx) + int'(out_valid);
    end
    chk("post-rst quiet", n_bsy, 0);

    // Stray start pulses inside a frame
    start = 1;
    step();
    start = 0;
    n_enx = 0; n_ov = 0;
    for (int i = 0; i < 80; i++) begin
      n_enx += int'(enx); n_ov += int'(out_valid);
      start = (frame_cnt == 5 || frame_cnt == 50) && busy;
      step();
    end
    start = 0;
    chk("stray enx count", n_enx, 1);
    chk("stray ov count", n_ov, 1);
    chk("stray end busy", 32'(busy), 0);

    // Small configuration
    s_start = 1;
    step();
    s_start = 0;
    for (int i = 0; i < 12; i++) begin
      e_lane = (i == 11) ? 0 : (i <= 3) ? 1 : (i == 4) ? 2 : (i == 5) ? 4 : 8;
      chk($sformatf("s fc@%0d", i), 32'(s_fc), i);
      chk($sformatf("s tap@%0d", i), 32'(s_tap), (i < 9) ? i : 8);
      chk($sformatf("s acc@%0d", i), 32'(s_acc), (i < 9) ? 1 : 0);
      chk($sformatf("s lane@%0d", i), 32'(s_lane), e_lane);
      chk($sformatf("s enx@%0d", i), 32'(s_enx), (i == 10) ? 1 : 0);
      chk($sformatf("s ov@%0d", i), 32'(s_ov), (i == 11) ? 1 : 0);
      if (i < 11) chk($sformatf("s onehot@%0d", i), 32'($onehot(s_lane)), 1);
      step();
    end
    chk("s idle busy", 32'(s_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
